// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: 2-entry skid pipeline register with registered in_ready and synchronous flush.
// Optional perf counters (perf_stall_cnt, perf_bubble_cnt) when PIPE_REG_SKID_PERF_EN is defined.
module pipe_reg_skid #(
  parameter int PAYLOAD_W  = 48,
  parameter bit FLUSH_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy
`ifdef PIPE_REG_SKID_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_bubble_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t               r_state, w_state_nx;
  logic [PAYLOAD_W-1:0] r_main_d, r_skid_d;
  logic                 r_in_ready;
  logic                 w_main_v, w_skid_v, w_in_fire, w_out_fire, w_main_ld;
  // The occupancy state doubles as the valid bits: skid is only ever live behind a live main.
  assign w_main_v    = r_state != EMPTY;
  assign w_skid_v    = r_state == TWO;
  assign w_in_fire   = in_valid & r_in_ready;
  assign w_out_fire  = w_main_v & out_ready;
  assign w_main_ld   = !w_main_v | w_out_fire;
  assign in_ready    = r_in_ready;
  assign out_valid   = w_main_v;
  assign out_payload = r_main_d;
  assign occupancy   = r_state;
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      EMPTY:   w_state_nx = w_in_fire ? ONE : EMPTY;
      ONE:     w_state_nx = (w_in_fire == w_out_fire) ? ONE : (w_in_fire ? TWO : EMPTY);
      TWO:     w_state_nx = w_out_fire ? ONE : TWO;
      default: w_state_nx = EMPTY;
    endcase
    if (flush) w_state_nx = EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_in_ready <= w_state_nx != TWO;
    end
  end
  // Payloads only move on real transfers so an idle output keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_d <= '0;
      r_skid_d <= '0;
    end else if (flush) begin
      if (FLUSH_ZERO) begin
        r_main_d <= '0;
        r_skid_d <= '0;
      end
    end else begin
      if (w_main_ld && (w_skid_v || w_in_fire)) r_main_d <= w_skid_v ? r_skid_d : in_payload;
      if (w_in_fire && (!w_main_ld || w_skid_v)) r_skid_d <= in_payload;
    end
  end
`ifdef PIPE_REG_SKID_PERF_EN
  logic [31:0] r_stall_cnt, r_bubble_cnt;
  assign perf_stall_cnt  = r_stall_cnt;
  assign perf_bubble_cnt = r_bubble_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_main_v && !out_ready && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (!w_main_v && out_ready && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: randomized and directed checks of pipe_reg_skid against a queue-based model.
module tb_pipe_reg_skid;
  localparam int W  = 48;
  localparam bit FZ = 1'b1;
  logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_payload = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_payload;
  logic [1:0]   occupancy;
`ifdef PIPE_REG_SKID_PERF_EN
  logic [31:0]  perf_stall_cnt, perf_bubble_cnt;
`endif
  pipe_reg_skid #(.PAYLOAD_W(W), .FLUSH_ZERO(FZ)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .occupancy(occupancy)
`ifdef PIPE_REG_SKID_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );
  always #5 clk = ~clk;
  int           n_chk = 0, n_fail = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] m_out;
  bit           m_rdy;
  int unsigned  m_stall, m_bubble;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_out    = '0;
    m_rdy    = 1'b1;
    m_stall  = 0;
    m_bubble = 0;
  endtask
  task automatic cmp_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(m_rdy));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("out_payload", 64'(out_payload), 64'(m_out));
`ifdef PIPE_REG_SKID_PERF_EN
    chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
    chk("perf_bubble", 64'(perf_bubble_cnt), 64'(m_bubble));
`endif
  endtask
  task automatic step(input bit iv, input logic [W-1:0] ip, input bit ordy, input bit fl);
    bit inf, outf;
    in_valid   = iv;
    in_payload = ip;
    out_ready  = ordy;
    flush      = fl;
    @(posedge clk);
    inf  = iv && m_rdy;
    outf = q.size() > 0 && ordy;
    if (q.size() > 0 && !ordy) m_stall++;
    if (q.size() == 0 && ordy) m_bubble++;
    if (fl) begin
      q.delete();
      if (FZ) m_out = '0;
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(ip);
    end
    if (q.size() > 0) m_out = q[0];
    m_rdy = q.size() < 2;
    @(negedge clk);
    cmp_all();
  endtask
  initial begin
    logic [63:0] rnd;
    model_reset();
    repeat (2) @(negedge clk);
    cmp_all();
    rst_n = 1'b1;
    step(1'b1, 48'hA5A5, 1'b1, 1'b0);
    chk("first_payload", 64'(out_payload), 64'hA5A5);
    chk("first_ready", 64'(in_ready), 64'h1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, W'(i), 1'b1, 1'b0);
      chk("stream_payload", 64'(out_payload), 64'(i));
      chk("stream_occ", 64'(occupancy), 64'h1);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 48'h10, 1'b0, 1'b0);
    step(1'b1, 48'h20, 1'b0, 1'b0);
    chk("stall_occ", 64'(occupancy), 64'h2);
    chk("stall_ready", 64'(in_ready), 64'h0);
    chk("stall_payload", 64'(out_payload), 64'h10);
    step(1'b1, 48'h99, 1'b0, 1'b0);
    chk("stall_hold", 64'(out_payload), 64'h10);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_second", 64'(out_payload), 64'h20);
    chk("drain_ready", 64'(in_ready), 64'h1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 64'(out_valid), 64'h0);
    step(1'b1, 48'h30, 1'b0, 1'b0);
    step(1'b1, 48'h40, 1'b0, 1'b0);
    step(1'b1, 48'h50, 1'b0, 1'b1);
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_occ", 64'(occupancy), 64'h0);
    chk("flush_payload", 64'(out_payload), 64'h0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_no50", 64'(out_valid), 64'h0);
    step(1'b1, 48'h60, 1'b0, 1'b0);
    step(1'b1, 48'h70, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_ready", 64'(in_ready), 64'h1);
    chk("arst_occ", 64'(occupancy), 64'h0);
    cmp_all();
    @(negedge clk);
    rst_n = 1'b1;
`ifdef PIPE_REG_SKID_PERF_EN
    step(1'b1, 48'h80, 1'b0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b0, 1'b0);
    chk("perf_stall5", 64'(perf_stall_cnt), 64'h5);
    step(1'b0, '0, 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    chk("perf_bubble3", 64'(perf_bubble_cnt), 64'h3);
`endif
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), rnd[W-1:0], $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
